axi_lite_regbank: RTL

Parametrised AXI4-Lite slave register bank with Vitis-style ap_ctrl_hs control, interrupt logic and a configurable number of write (control) and read (status) registers. It replaces the fixed four-register control slave in the forwarder. It accepts AW and W independently and merges WSTRB per byte instead of zeroing unstrobed lanes. It sits between the PS AXI-Lite interconnect and the forwarder datapath.

---
 rtl/axi_lite_regbank_pkg.sv | 44 ++++
 rtl/axi_lite_regbank_if.sv | 33 +++
 rtl/axi_lite_regbank_ap_ctrl.sv | 80 ++++++++
 rtl/axi_lite_regbank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_regbank_pkg.sv
// Shared constants and address decode helpers for the AXI4-Lite register bank.
package axi_lite_regbank_pkg;

  localparam int ADDR_CTRL = 'h00;
  localparam int ADDR_GIE  = 'h04;
  localparam int ADDR_IER  = 'h08;
  localparam int ADDR_ISR  = 'h0C;
  localparam int ADDR_REGS = 'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_START        = 0;
  localparam int CTRL_DONE         = 1;
  localparam int CTRL_IDLE         = 2;
  localparam int CTRL_READY        = 3;
  localparam int CTRL_AUTO_RESTART = 7;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_GIE,
    SEL_IER,
    SEL_ISR,
    SEL_WR,
    SEL_RD,
    SEL_NONE
  } sel_e;

  function automatic int regIndex(input logic [31:0] addr);
    return int'(addr >> 2);
  endfunction

  // Word index -> register class; WR regs start at ADDR_REGS, RD regs follow them.
  function automatic sel_e decodeAddr(input int idx, input int nWr, input int nRd);
    if (idx == ADDR_CTRL / 4) return SEL_CTRL;
    if (idx == ADDR_GIE / 4) return SEL_GIE;
    if (idx == ADDR_IER / 4) return SEL_IER;
    if (idx == ADDR_ISR / 4) return SEL_ISR;
    if (idx >= ADDR_REGS / 4 && idx < ADDR_REGS / 4 + nWr) return SEL_WR;
    if (idx >= ADDR_REGS / 4 + nWr && idx < ADDR_REGS / 4 + nWr + nRd) return SEL_RD;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle for the register bank; master drives requests, slave answers.
interface axi_lite_regbank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_regbank_ap_ctrl.sv
// ap_ctrl_hs handshake state (start/done/ready/idle/auto_restart) and the GIE/IER/ISR interrupt block.
module ap_ctrl_hs_regs
  import axi_lite_regbank_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        en_i,
  input  logic        ctrlWr_i,
  input  logic        gieWr_i,
  input  logic        ierWr_i,
  input  logic        isrWr_i,
  input  logic        ctrlRd_i,
  input  logic [1:0]  wrLow_i,
  input  logic        wrAutoRestart_i,
  input  logic        apDone_i,
  input  logic        apReady_i,
  input  logic        apIdle_i,
  output logic        apStart_o,
  output logic        interrupt_o,
  output logic [31:0] ctrlRdata_o,
  output logic [31:0] gieRdata_o,
  output logic [31:0] ierRdata_o,
  output logic [31:0] isrRdata_o
);

  logic       start_q, done_q, ready_q, autoRestart_q, idlePrev_q, gie_q;
  logic [1:0] ier_q, isr_q;
  logic [1:0] isrSet;
  logic       doneSet, readySet;

  assign doneSet  = apDone_i | (autoRestart_q & apIdle_i & ~idlePrev_q);
  assign readySet = apReady_i & ~autoRestart_q;
  assign isrSet   = ier_q & {apReady_i, apDone_i};

  // Set events win over clear-on-read and toggle-on-write; a start write wins over ap_ready.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
      autoRestart_q <= 1'b0;
      idlePrev_q    <= 1'b0;
      gie_q         <= 1'b0;
      ier_q         <= 2'b00;
      isr_q         <= 2'b00;
    end else if (en_i) begin
      idlePrev_q <= apIdle_i;
      if (ctrlWr_i && wrLow_i[0]) start_q <= 1'b1;
      else if (apReady_i)         start_q <= autoRestart_q;
      if (ctrlWr_i) autoRestart_q <= wrAutoRestart_i;
      if (doneSet)       done_q <= 1'b1;
      else if (ctrlRd_i) done_q <= 1'b0;
      if (readySet)      ready_q <= 1'b1;
      else if (ctrlRd_i) ready_q <= 1'b0;
      if (gieWr_i) gie_q <= wrLow_i[0];
      if (ierWr_i) ier_q <= wrLow_i;
      for (int b = 0; b < 2; b++) begin
        if (isrSet[b])                   isr_q[b] <= 1'b1;
        else if (isrWr_i && wrLow_i[b])  isr_q[b] <= ~isr_q[b];
      end
    end
  end

  assign apStart_o   = start_q;
  assign interrupt_o = gie_q & (|isr_q);

  always_comb begin
    ctrlRdata_o                    = '0;
    ctrlRdata_o[CTRL_START]        = start_q;
    ctrlRdata_o[CTRL_DONE]         = done_q;
    ctrlRdata_o[CTRL_IDLE]         = apIdle_i;
    ctrlRdata_o[CTRL_READY]        = ready_q;
    ctrlRdata_o[CTRL_AUTO_RESTART] = autoRestart_q;
  end

  assign gieRdata_o = {31'b0, gie_q};
  assign ierRdata_o = {30'b0, ier_q};
  assign isrRdata_o = {30'b0, isr_q};

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with ap_ctrl_hs control, N_WR_REGS control and N_RD_REGS status words.
// Optional build macro AXI_LITE_REGBANK_SLVERR_EN: unmapped accesses and RD-reg writes answer SLVERR.
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_WR_REGS          = 4,
  parameter int N_RD_REGS          = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   ACLK_EN,
  axi_lite_regbank_if.slave      s_axi,
  output logic                   ap_start,
  input  logic                   ap_done,
  input  logic                   ap_ready,
  input  logic                   ap_idle,
  output logic                   interrupt,
  output logic [N_WR_REGS*32-1:0] reg_o,
  output logic [N_WR_REGS-1:0]   reg_wr_o,
  input  logic [N_RD_REGS*32-1:0] reg_i
);

  logic                            awHeld_q, wHeld_q, bValid_q, rValid_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awAddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wData_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wStrb_q;
  logic [1:0]                      bResp_q, rResp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rData_q;
  logic [31:0]                     wrRegs_q [N_WR_REGS];
  logic [N_WR_REGS-1:0]            regWr_q;

  logic        awHs, wHs, bHs, arHs, rHs, commit;
  logic        ctrlWr, gieWr, ierWr, isrWr, ctrlRd;
  int          wrWord, rdWord, wrIdx, rdIdx;
  sel_e        wrSel, rdSel;
  logic [31:0] wrMask, rdData;
  logic [31:0] ctrlRdata, gieRdata, ierRdata, isrRdata;
  logic [1:0]  wrResp, rdResp;

  assign s_axi.AWREADY = ACLK_EN & ~ARESET & ~awHeld_q & ~bValid_q;
  assign s_axi.WREADY  = ACLK_EN & ~ARESET & ~wHeld_q & ~bValid_q;
  assign s_axi.ARREADY = ACLK_EN & ~ARESET & ~rValid_q;
  assign s_axi.BVALID  = bValid_q;
  assign s_axi.BRESP   = bResp_q;
  assign s_axi.RVALID  = rValid_q;
  assign s_axi.RDATA   = rData_q;
  assign s_axi.RRESP   = rResp_q;

  assign awHs   = s_axi.AWVALID & s_axi.AWREADY;
  assign wHs    = s_axi.WVALID & s_axi.WREADY;
  assign arHs   = s_axi.ARVALID & s_axi.ARREADY;
  assign bHs    = bValid_q & s_axi.BREADY;
  assign rHs    = rValid_q & s_axi.RREADY;
  assign commit = ACLK_EN & awHeld_q & wHeld_q;

  always_comb begin
    wrWord = regIndex(32'(awAddr_q));
    rdWord = regIndex(32'(s_axi.ARADDR));
    wrSel  = decodeAddr(wrWord, N_WR_REGS, N_RD_REGS);
    rdSel  = decodeAddr(rdWord, N_WR_REGS, N_RD_REGS);
    wrIdx  = wrWord - ADDR_REGS / 4;
    rdIdx  = rdWord - ADDR_REGS / 4;
  end

  assign wrMask = {{8{wStrb_q[3]}}, {8{wStrb_q[2]}}, {8{wStrb_q[1]}}, {8{wStrb_q[0]}}};

  assign ctrlWr = commit & (wrSel == SEL_CTRL) & wStrb_q[0];
  assign gieWr  = commit & (wrSel == SEL_GIE) & wStrb_q[0];
  assign ierWr  = commit & (wrSel == SEL_IER) & wStrb_q[0];
  assign isrWr  = commit & (wrSel == SEL_ISR) & wStrb_q[0];
  assign ctrlRd = arHs & (rdSel == SEL_CTRL);

`ifdef AXI_LITE_REGBANK_SLVERR_EN
  assign wrResp = (wrSel == SEL_RD || wrSel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
  assign rdResp = (rdSel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
`else
  assign wrResp = RESP_OKAY;
  assign rdResp = RESP_OKAY;
`endif

  always_comb begin
    rdData = '0;
    case (rdSel)
      SEL_CTRL: rdData = ctrlRdata;
      SEL_GIE:  rdData = gieRdata;
      SEL_IER:  rdData = ierRdata;
      SEL_ISR:  rdData = isrRdata;
      SEL_WR: begin
        for (int i = 0; i < N_WR_REGS; i++)
          if (rdIdx == i) rdData = wrRegs_q[i];
      end
      SEL_RD: begin
        for (int j = 0; j < N_RD_REGS; j++)
          if (rdIdx - N_WR_REGS == j) rdData = reg_i[32*j +: 32];
      end
      default: rdData = '0;
    endcase
  end

  // AW and W are latched independently and committed together one cycle after both are held.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awHeld_q <= 1'b0;
      wHeld_q  <= 1'b0;
      bValid_q <= 1'b0;
      rValid_q <= 1'b0;
      awAddr_q <= '0;
      wData_q  <= '0;
      wStrb_q  <= '0;
      bResp_q  <= RESP_OKAY;
      rResp_q  <= RESP_OKAY;
      rData_q  <= '0;
      regWr_q  <= '0;
      for (int i = 0; i < N_WR_REGS; i++) wrRegs_q[i] <= '0;
    end else if (ACLK_EN) begin
      if (awHs) begin
        awHeld_q <= 1'b1;
        awAddr_q <= s_axi.AWADDR;
      end
      if (wHs) begin
        wHeld_q <= 1'b1;
        wData_q <= s_axi.WDATA;
        wStrb_q <= s_axi.WSTRB;
      end
      if (commit) begin
        awHeld_q <= 1'b0;
        wHeld_q  <= 1'b0;
        bValid_q <= 1'b1;
        bResp_q  <= wrResp;
      end else if (bHs) begin
        bValid_q <= 1'b0;
      end
      regWr_q <= '0;
      for (int i = 0; i < N_WR_REGS; i++) begin
        if (commit && wrSel == SEL_WR && wrIdx == i) begin
          wrRegs_q[i] <= (wData_q & wrMask) | (wrRegs_q[i] & ~wrMask);
          regWr_q[i]  <= 1'b1;
        end
      end
      if (arHs) begin
        rValid_q <= 1'b1;
        rData_q  <= rdData;
        rResp_q  <= rdResp;
      end else if (rHs) begin
        rValid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_WR_REGS; i++) begin : gPack
    assign reg_o[32*i +: 32] = wrRegs_q[i];
  end

  assign reg_wr_o = regWr_q & {N_WR_REGS{ACLK_EN}};

  ap_ctrl_hs_regs uCtrl (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .en_i            (ACLK_EN),
    .ctrlWr_i        (ctrlWr),
    .gieWr_i         (gieWr),
    .ierWr_i         (ierWr),
    .isrWr_i         (isrWr),
    .ctrlRd_i        (ctrlRd),
    .wrLow_i         (wData_q[1:0]),
    .wrAutoRestart_i (wData_q[7]),
    .apDone_i        (ap_done),
    .apReady_i       (ap_ready),
    .apIdle_i        (ap_idle),
    .apStart_o       (ap_start),
    .interrupt_o     (interrupt),
    .ctrlRdata_o     (ctrlRdata),
    .gieRdata_o      (gieRdata),
    .ierRdata_o      (ierRdata),
    .isrRdata_o      (isrRdata)
  );

endmodule
